// File: rtl/tpu_top.sv
// 4x4 unsigned 8-bit matrix-multiply accelerator: C = A*B or C += A*B over three dual-port RAMs.
// APB slave with no wait states; a job completes 18 cycles after the START write.
module tpu_dpram #(
  parameter int AW = 10,
  parameter int N  = 4,
  parameter int DW = 8
) (
  input  logic            clk,
  input  logic [AW-1:0]   addr_int,
  input  logic [N*DW-1:0] wdata_int,
  input  logic [N-1:0]    we_int,
  output logic [N*DW-1:0] rdata_int,
  input  logic [AW-1:0]   addr_ext,
  input  logic [N*DW-1:0] wdata_ext,
  input  logic [N-1:0]    we_ext,
  output logic [N*DW-1:0] rdata_ext
);
  logic [N*DW-1:0] mem [2**AW];

  // The internal write comes second, so it wins when both ports write the same word in the same cycle.
  always_ff @(posedge clk) begin
    for (int k = 0; k < N; k++) begin
      if (we_ext[k]) mem[addr_ext][k*DW +: DW] <= wdata_ext[k*DW +: DW];
      if (we_int[k]) mem[addr_int][k*DW +: DW] <= wdata_int[k*DW +: DW];
    end
    rdata_int <= mem[addr_int];
    rdata_ext <= mem[addr_ext];
  end
endmodule

module tpu_top #(
  parameter int REG_ADDRWIDTH = 8,
  parameter int REG_DATAWIDTH = 32,
  parameter int AWIDTH        = 10,
  parameter int DWIDTH        = 8,
  parameter int MAT_MUL_SIZE  = 4,
  parameter int MASK_WIDTH    = 4
) (
  input  logic                           clk,
  input  logic                           resetn,
  input  logic [REG_ADDRWIDTH-1:0]       PADDR,
  input  logic                           PWRITE,
  input  logic                           PSEL,
  input  logic                           PENABLE,
  input  logic [REG_DATAWIDTH-1:0]       PWDATA,
  output logic [REG_DATAWIDTH-1:0]       PRDATA,
  output logic                           PREADY,
  input  logic [AWIDTH-1:0]              bram_addr_a_ext,
  input  logic [MAT_MUL_SIZE*DWIDTH-1:0] bram_wdata_a_ext,
  input  logic [MASK_WIDTH-1:0]          bram_we_a_ext,
  output logic [MAT_MUL_SIZE*DWIDTH-1:0] bram_rdata_a_ext,
  input  logic [AWIDTH-1:0]              bram_addr_b_ext,
  input  logic [MAT_MUL_SIZE*DWIDTH-1:0] bram_wdata_b_ext,
  input  logic [MASK_WIDTH-1:0]          bram_we_b_ext,
  output logic [MAT_MUL_SIZE*DWIDTH-1:0] bram_rdata_b_ext,
  input  logic [AWIDTH-1:0]              bram_addr_c_ext,
  input  logic [MAT_MUL_SIZE*DWIDTH-1:0] bram_wdata_c_ext,
  input  logic [MASK_WIDTH-1:0]          bram_we_c_ext,
  output logic [MAT_MUL_SIZE*DWIDTH-1:0] bram_rdata_c_ext
);
  localparam int N  = MAT_MUL_SIZE;
  localparam int RW = N*DWIDTH;
  localparam int CW = $clog2(N) + 1;
  localparam int IW = $clog2(N);

  localparam logic [REG_ADDRWIDTH-1:0] A_CTRL   = 'h00;
  localparam logic [REG_ADDRWIDTH-1:0] A_STATUS = 'h04;
  localparam logic [REG_ADDRWIDTH-1:0] A_ADDR_A = 'h08;
  localparam logic [REG_ADDRWIDTH-1:0] A_ADDR_B = 'h0C;
  localparam logic [REG_ADDRWIDTH-1:0] A_ADDR_C = 'h10;

  typedef enum logic [2:0] {S_IDLE, S_LOAD_B, S_RD_A, S_CALC, S_WR_C, S_DONE} state_t;

  state_t             state;
  logic [CW-1:0]      cnt;
  logic [IW-1:0]      row;
  logic               ctrl_accum, accum_run, busy, done;
  logic [AWIDTH-1:0]  base_a, base_b, base_c;
  logic [AWIDTH-1:0]  addr_a, addr_b, addr_c;
  logic [RW-1:0]      wdata_c;
  logic [N-1:0]       we_c;
  logic [RW-1:0]      b_row [N];
  logic [RW-1:0]      rdata_a, rdata_b, rdata_c;
  logic [RW-1:0]      calc_row;
  logic [REG_DATAWIDTH-1:0] rd_data;
  logic               apb_wr, apb_rd, start_req;
  logic [DWIDTH-1:0]  acc;
  logic [2*DWIDTH-1:0] prod;
  logic               unused_pwdata;

  assign PREADY    = PSEL & PENABLE;
  assign apb_wr    = PSEL & PENABLE & PWRITE;
  assign apb_rd    = PSEL & PENABLE & ~PWRITE;
  assign start_req = apb_wr && (PADDR == A_CTRL) && PWDATA[0];
  assign unused_pwdata = ^PWDATA[REG_DATAWIDTH-1:AWIDTH];

  always_comb begin
    rd_data = '0;
    case (PADDR)
      A_CTRL:   rd_data = {{(REG_DATAWIDTH-2){1'b0}}, ctrl_accum, 1'b0};
      A_STATUS: rd_data = {{(REG_DATAWIDTH-2){1'b0}}, busy, done};
      A_ADDR_A: rd_data = {{(REG_DATAWIDTH-AWIDTH){1'b0}}, base_a};
      A_ADDR_B: rd_data = {{(REG_DATAWIDTH-AWIDTH){1'b0}}, base_b};
      A_ADDR_C: rd_data = {{(REG_DATAWIDTH-AWIDTH){1'b0}}, base_c};
      default:  rd_data = '0;
    endcase
  end

  // Products are 16 bits, but only the low byte of the sum survives, so accumulate in 8 bits.
  always_comb begin
    calc_row = '0;
    acc      = '0;
    prod     = '0;
    for (int j = 0; j < N; j++) begin
      acc = accum_run ? rdata_c[j*DWIDTH +: DWIDTH] : '0;
      for (int k = 0; k < N; k++) begin
        prod = rdata_a[k*DWIDTH +: DWIDTH] * b_row[k][j*DWIDTH +: DWIDTH];
        acc  = acc + prod[DWIDTH-1:0];
      end
      calc_row[j*DWIDTH +: DWIDTH] = acc;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state      <= S_IDLE;
      cnt        <= '0;
      row        <= '0;
      ctrl_accum <= 1'b0;
      accum_run  <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
      base_a     <= '0;
      base_b     <= '0;
      base_c     <= '0;
      addr_a     <= '0;
      addr_b     <= '0;
      addr_c     <= '0;
      wdata_c    <= '0;
      we_c       <= '0;
      PRDATA     <= '0;
      for (int k = 0; k < N; k++) b_row[k] <= '0;
    end else begin
      if (apb_rd) PRDATA <= rd_data;
      if (apb_wr) begin
        case (PADDR)
          A_CTRL:   ctrl_accum <= PWDATA[1];
          A_ADDR_A: base_a     <= PWDATA[AWIDTH-1:0];
          A_ADDR_B: base_b     <= PWDATA[AWIDTH-1:0];
          A_ADDR_C: base_c     <= PWDATA[AWIDTH-1:0];
          default:  ;
        endcase
      end

      case (state)
        S_IDLE: begin
          if (start_req) begin
            busy      <= 1'b1;
            done      <= 1'b0;
            accum_run <= PWDATA[1];
            addr_a    <= base_a;
            addr_b    <= base_b;
            addr_c    <= base_c;
            cnt       <= '0;
            row       <= '0;
            state     <= S_LOAD_B;
          end
        end
        S_LOAD_B: begin
          // Rows arrive one cycle after their address; shifting in leaves row 0 at index 0.
          if (cnt != '0) begin
            b_row[N-1] <= rdata_b;
            for (int k = 0; k < N-1; k++) b_row[k] <= b_row[k+1];
          end
          addr_b <= addr_b + AWIDTH'(1);
          if (cnt == CW'(N)) state <= S_RD_A;
          else               cnt   <= cnt + CW'(1);
        end
        S_RD_A: state <= S_CALC;
        S_CALC: begin
          wdata_c <= calc_row;
          we_c    <= '1;
          state   <= S_WR_C;
        end
        S_WR_C: begin
          we_c <= '0;
          if (row == IW'(N-1)) begin
            state <= S_DONE;
          end else begin
            row    <= row + IW'(1);
            addr_a <= addr_a + AWIDTH'(1);
            addr_c <= addr_c + AWIDTH'(1);
            state  <= S_RD_A;
          end
        end
        S_DONE: begin
          done  <= 1'b1;
          busy  <= 1'b0;
          state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  tpu_dpram #(.AW(AWIDTH), .N(N), .DW(DWIDTH)) u_ram_a (
    .clk(clk), .addr_int(addr_a), .wdata_int('0), .we_int('0), .rdata_int(rdata_a),
    .addr_ext(bram_addr_a_ext), .wdata_ext(bram_wdata_a_ext), .we_ext(bram_we_a_ext),
    .rdata_ext(bram_rdata_a_ext)
  );

  tpu_dpram #(.AW(AWIDTH), .N(N), .DW(DWIDTH)) u_ram_b (
    .clk(clk), .addr_int(addr_b), .wdata_int('0), .we_int('0), .rdata_int(rdata_b),
    .addr_ext(bram_addr_b_ext), .wdata_ext(bram_wdata_b_ext), .we_ext(bram_we_b_ext),
    .rdata_ext(bram_rdata_b_ext)
  );

  tpu_dpram #(.AW(AWIDTH), .N(N), .DW(DWIDTH)) u_ram_c (
    .clk(clk), .addr_int(addr_c), .wdata_int(wdata_c), .we_int(we_c), .rdata_int(rdata_c),
    .addr_ext(bram_addr_c_ext), .wdata_ext(bram_wdata_c_ext), .we_ext(bram_we_c_ext),
    .rdata_ext(bram_rdata_c_ext)
  );
endmodule

// File: tb/tb_tpu_top.sv
// Directed bench for tpu_top: register access, identity/constant multiplies, accumulate, wrap, START while busy.
module tb_tpu_top;
  logic        clk, resetn;
  logic [7:0]  PADDR;
  logic        PWRITE, PSEL, PENABLE;
  logic [31:0] PWDATA, PRDATA;
  logic        PREADY;
  logic [9:0]  addr_a, addr_b, addr_c;
  logic [31:0] wdata_a, wdata_b, wdata_c;
  logic [3:0]  we_a, we_b, we_c;
  logic [31:0] rdata_a, rdata_b, rdata_c;

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;
  logic pready_seen;

  tpu_top dut (
    .clk(clk), .resetn(resetn),
    .PADDR(PADDR), .PWRITE(PWRITE), .PSEL(PSEL), .PENABLE(PENABLE), .PWDATA(PWDATA),
    .PRDATA(PRDATA), .PREADY(PREADY),
    .bram_addr_a_ext(addr_a), .bram_wdata_a_ext(wdata_a), .bram_we_a_ext(we_a), .bram_rdata_a_ext(rdata_a),
    .bram_addr_b_ext(addr_b), .bram_wdata_b_ext(wdata_b), .bram_we_b_ext(we_b), .bram_rdata_b_ext(rdata_b),
    .bram_addr_c_ext(addr_c), .bram_wdata_c_ext(wdata_c), .bram_we_c_ext(we_c), .bram_rdata_c_ext(rdata_c)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic apb_write(input logic [7:0] a, input logic [31:0] d);
    @(posedge clk); #1;
    PADDR = a; PWDATA = d; PWRITE = 1'b1; PSEL = 1'b1; PENABLE = 1'b0;
    @(posedge clk); #1;
    PENABLE = 1'b1;
    @(posedge clk); #1;
    PSEL = 1'b0; PENABLE = 1'b0; PWRITE = 1'b0;
  endtask

  task automatic apb_read(input logic [7:0] a, output logic [31:0] d);
    @(posedge clk); #1;
    PADDR = a; PWRITE = 1'b0; PSEL = 1'b1; PENABLE = 1'b0;
    @(posedge clk); #1;
    PENABLE = 1'b1;
    #1 pready_seen = PREADY;
    @(posedge clk); #1;
    d = PRDATA;
    PSEL = 1'b0; PENABLE = 1'b0;
  endtask

  task automatic load_ab(input logic [9:0] base_a, input logic [31:0] row_a [4],
                         input logic [9:0] base_b, input logic [31:0] row_b [4]);
    for (int r = 0; r < 4; r++) begin
      @(posedge clk); #1;
      addr_a = base_a + 10'(r); wdata_a = row_a[r]; we_a = 4'hF;
      addr_b = base_b + 10'(r); wdata_b = row_b[r]; we_b = 4'hF;
      @(posedge clk); #1;
      we_a = 4'h0; we_b = 4'h0;
    end
  endtask

  task automatic check_c(input string tag, input logic [9:0] base, input logic [31:0] exp [4]);
    for (int r = 0; r < 4; r++) begin
      @(posedge clk); #1;
      addr_c = base + 10'(r);
      @(posedge clk); #1;
      check($sformatf("%s_row%0d", tag, r), rdata_c, exp[r]);
    end
  endtask

  // Polls STATUS after a START; also bounds the completion latency.
  task automatic wait_done(input string tag, input int t0);
    logic [31:0] st;
    int polls;
    polls = 0;
    st = '0;
    do begin
      apb_read(8'h04, st);
      polls++;
    end while (!st[0] && polls < 40);
    check({tag, "_status"}, st, 32'h1);
    check({tag, "_latency_ok"}, 32'((cyc - t0) <= 27), 32'h1);
  endtask

  task automatic start_run(input string tag, input logic [31:0] ctrl);
    int t0;
    apb_write(8'h00, ctrl);
    t0 = cyc;
    wait_done(tag, t0);
  endtask

  logic [31:0] rd;
  logic [31:0] ra [4];
  logic [31:0] rb [4];
  logic [31:0] rc [4];
  int t0;

  initial begin
    resetn = 1'b0;
    PADDR = '0; PWRITE = 1'b0; PSEL = 1'b0; PENABLE = 1'b0; PWDATA = '0;
    addr_a = '0; addr_b = '0; addr_c = '0;
    wdata_a = '0; wdata_b = '0; wdata_c = '0;
    we_a = '0; we_b = '0; we_c = '0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_prdata", PRDATA, 32'h0);
    check("reset_pready", {31'b0, PREADY}, 32'h0);
    resetn = 1'b1;

    // Test 1: register map basics
    apb_read(8'h04, rd);
    check("t1_status", rd, 32'h0);
    check("t1_pready_access", {31'b0, pready_seen}, 32'h1);
    apb_write(8'h08, 32'h10);
    apb_read(8'h08, rd);
    check("t1_addr_a", rd, 32'h10);
    apb_write(8'h20, 32'hDEAD_BEEF);
    apb_read(8'h20, rd);
    check("t1_unmapped", rd, 32'h0);

    // Test 2: identity * B = B
    ra = '{32'h0000_0001, 32'h0000_0100, 32'h0001_0000, 32'h0100_0000};
    rb = '{32'h0403_0201, 32'h0807_0605, 32'h0C0B_0A09, 32'h100F_0E0D};
    load_ab(10'h000, ra, 10'h010, rb);
    apb_write(8'h08, 32'h00);
    apb_write(8'h0C, 32'h10);
    apb_write(8'h10, 32'h20);
    start_run("t2", 32'h1);
    check_c("t2_c", 10'h020, rb);

    // Test 3: all 2 * all 3 -> 4*6 = 24
    ra = '{4{32'h0202_0202}};
    rb = '{4{32'h0303_0303}};
    load_ab(10'h000, ra, 10'h010, rb);
    start_run("t3", 32'h1);
    rc = '{4{32'h1818_1818}};
    check_c("t3_c", 10'h020, rc);

    // Test 4: accumulate onto previous 24 -> 48
    start_run("t4", 32'h3);
    rc = '{4{32'h3030_3030}};
    check_c("t4_c", 10'h020, rc);
    apb_read(8'h00, rd);
    check("t4_ctrl_readback", rd, 32'h2);

    // Test 5: 16*16*4 = 1024 wraps to 0; non-accumulate overwrites 0x30
    ra = '{4{32'h1010_1010}};
    rb = '{4{32'h1010_1010}};
    load_ab(10'h000, ra, 10'h010, rb);
    start_run("t5", 32'h1);
    rc = '{4{32'h0000_0000}};
    check_c("t5_c", 10'h020, rc);

    // Test 6: second START while busy is ignored; a single accumulate onto 0 gives 24
    ra = '{4{32'h0202_0202}};
    rb = '{4{32'h0303_0303}};
    load_ab(10'h000, ra, 10'h010, rb);
    apb_write(8'h00, 32'h3);
    t0 = cyc;
    apb_write(8'h00, 32'h3);
    apb_read(8'h04, rd);
    check("t6_busy", rd, 32'h2);
    wait_done("t6", t0);
    rc = '{4{32'h1818_1818}};
    check_c("t6_c", 10'h020, rc);
    repeat (30) @(posedge clk);
    apb_read(8'h04, rd);
    check("t6_status_after", rd, 32'h1);
    check_c("t6_c_after", 10'h020, rc);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
